// File: rtl/execute_muldiv_unit_if.sv
// Request/response bundle between the execute stage and the multi-cycle
// multiply/divide unit. The master side is the pipeline, the slave side is
// the unit itself.
interface execute_muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic [XLEN-1:0] left_operand;
    logic [XLEN-1:0] right_operand;
    logic [4:0]      rd_in;
    logic            flush;
    logic            stall;
    logic            out_valid;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_out;

    modport master (
        output in_valid, op, left_operand, right_operand, rd_in, flush,
        input  in_ready, stall, out_valid, result, rd_out
    );

    modport slave (
        input  in_valid, op, left_operand, right_operand, rd_in, flush,
        output in_ready, stall, out_valid, result, rd_out
    );
endinterface

// File: rtl/execute_muldiv_unit.sv
// Multi-cycle RISC-V M-extension unit for the execute stage.
// Multiplies with a radix-2 shift-add loop and divides with a restoring
// loop, one bit per cycle, on operand magnitudes; signs are re-applied when
// the last iteration retires. Divide-by-zero and signed-overflow divides
// carry a precomputed result and may bypass the loop when FAST_SPECIAL=1.
module execute_muldiv_unit #(
    parameter int XLEN         = 32,
    parameter int FAST_SPECIAL = 1
) (
    input logic                  clk,
    input logic                  rst,
    execute_muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    logic [CW-1:0] count;

    // Operation context captured at accept.
    logic [2:0]        op_p0;
    logic [4:0]        rd_p0;
    logic              neg_a_p0;
    logic              neg_b_p0;
    logic [XLEN-1:0]   mag_b_p0;
    logic              special_p0;
    logic [XLEN-1:0]   special_res_p0;
    // Shared iteration register: {hi, lo} product for multiply,
    // {partial remainder, quotient} for divide.
    logic [2*XLEN-1:0] acc;

    logic              accept;
    logic              signed_a;
    logic              signed_b;
    logic              neg_a_in;
    logic              neg_b_in;
    logic [XLEN-1:0]   mag_a_in;
    logic [XLEN-1:0]   mag_b_in;
    logic              div_zero_in;
    logic              overflow_in;
    logic              special_in;
    logic [XLEN-1:0]   special_res_in;

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN-1:0]   div_diff;
    logic [2*XLEN-1:0] acc_next;
    logic [2*XLEN-1:0] prod_signed;
    logic [XLEN-1:0]   final_res;

    function automatic logic [XLEN-1:0] apply_sign(input logic [XLEN-1:0] val,
                                                   input logic neg);
        return neg ? (~val + XLEN'(1)) : val;
    endfunction

    function automatic logic [2*XLEN-1:0] apply_sign_wide(input logic [2*XLEN-1:0] val,
                                                          input logic neg);
        return neg ? (~val + (2*XLEN)'(1)) : val;
    endfunction

    assign accept     = (state == IDLE) && bus.in_valid && !bus.flush;
    assign bus.in_ready = (state == IDLE);
    assign bus.stall    = accept || (state == CALC);

    // Decode operand signedness and special divides from the incoming request.
    always_comb begin
        signed_a = 1'b0;
        signed_b = 1'b0;
        case (bus.op)
            OP_MULH, OP_DIV, OP_REM: begin
                signed_a = 1'b1;
                signed_b = 1'b1;
            end
            OP_MULHSU: signed_a = 1'b1;
            default: ;
        endcase

        neg_a_in = signed_a && bus.left_operand[XLEN-1];
        neg_b_in = signed_b && bus.right_operand[XLEN-1];
        mag_a_in = apply_sign(bus.left_operand, neg_a_in);
        mag_b_in = apply_sign(bus.right_operand, neg_b_in);

        div_zero_in = bus.op[2] && (bus.right_operand == '0);
        overflow_in = ((bus.op == OP_DIV) || (bus.op == OP_REM)) &&
                      (bus.left_operand == {1'b1, {(XLEN-1){1'b0}}}) &&
                      (bus.right_operand == '1);
        special_in  = div_zero_in || overflow_in;

        special_res_in = '0;
        if (div_zero_in) begin
            // REM/REMU (op[1]=1) return the dividend, DIV/DIVU all ones.
            special_res_in = bus.op[1] ? bus.left_operand : '1;
        end else if (overflow_in) begin
            special_res_in = bus.op[1] ? '0 : bus.left_operand;
        end
    end

    // One iteration step and the signed result it would retire.
    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_b_p0} : '0);
        div_shift = acc[2*XLEN-1:XLEN-1];
        div_diff  = div_shift[XLEN-1:0] - mag_b_p0;

        if (op_p0[2]) begin
            if (div_shift >= {1'b0, mag_b_p0}) begin
                acc_next = {div_diff, acc[XLEN-2:0], 1'b1};
            end else begin
                acc_next = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_next = {mul_sum, acc[XLEN-1:1]};
        end

        prod_signed = apply_sign_wide(acc_next, neg_a_p0 ^ neg_b_p0);

        final_res = '0;
        if (special_p0) begin
            final_res = special_res_p0;
        end else begin
            case (op_p0)
                OP_MUL:                       final_res = prod_signed[XLEN-1:0];
                OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_signed[2*XLEN-1:XLEN];
                OP_DIV, OP_DIVU:              final_res = apply_sign(acc_next[XLEN-1:0],
                                                                     neg_a_p0 ^ neg_b_p0);
                OP_REM, OP_REMU:              final_res = apply_sign(acc_next[2*XLEN-1:XLEN],
                                                                     neg_a_p0);
                default:                      final_res = '0;
            endcase
        end
    end

    // Datapath registers: capture the request on accept, iterate in CALC.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_p0          <= bus.op;
            rd_p0          <= bus.rd_in;
            neg_a_p0       <= neg_a_in;
            neg_b_p0       <= neg_b_in;
            mag_b_p0       <= mag_b_in;
            special_p0     <= special_in;
            special_res_p0 <= special_res_in;
            acc            <= {{XLEN{1'b0}}, mag_a_in};
        end else if (state == CALC) begin
            acc <= acc_next;
        end
    end

    // Control FSM; flush outranks every transition, reset outranks flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            count         <= '0;
            bus.out_valid <= 1'b0;
            bus.result    <= '0;
            bus.rd_out    <= '0;
        end else if (bus.flush) begin
            state         <= IDLE;
            count         <= '0;
            bus.out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.out_valid <= 1'b0;
                    count         <= '0;
                    if (bus.in_valid) begin
                        if ((FAST_SPECIAL != 0) && special_in) begin
                            state         <= DONE;
                            bus.out_valid <= 1'b1;
                            bus.result    <= special_res_in;
                            bus.rd_out    <= bus.rd_in;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (count == LAST) begin
                        state         <= DONE;
                        count         <= '0;
                        bus.out_valid <= 1'b1;
                        bus.result    <= final_res;
                        bus.rd_out    <= rd_p0;
                    end else begin
                        count <= count + CW'(1);
                    end
                end
                DONE: begin
                    state         <= IDLE;
                    bus.out_valid <= 1'b0;
                end
                default: begin
                    state         <= IDLE;
                    bus.out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_execute_muldiv_unit.sv
// Bench for execute_muldiv_unit: one instance with FAST_SPECIAL=1 and one
// with FAST_SPECIAL=0 receive identical requests. Directed vectors, random
// requests against an arithmetic reference model, and hand-written flush and
// reset sequences.
module tb_execute_muldiv_unit;
    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    execute_muldiv_unit_if #(.XLEN(XLEN)) bus_f ();
    execute_muldiv_unit_if #(.XLEN(XLEN)) bus_s ();

    execute_muldiv_unit #(.XLEN(XLEN), .FAST_SPECIAL(1)) dut_f (
        .clk(clk), .rst(rst), .bus(bus_f)
    );
    execute_muldiv_unit #(.XLEN(XLEN), .FAST_SPECIAL(0)) dut_s (
        .clk(clk), .rst(rst), .bus(bus_s)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] want;
        bit          sp;
    } vec_t;

    vec_t        vecs[16];
    int          checks = 0;
    int          fails  = 0;
    logic [31:0] last_res;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, want);
        end
    endtask

    task automatic drive(input logic v, input logic fl, input logic [2:0] o,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        bus_f.in_valid = v;  bus_s.in_valid = v;
        bus_f.flush    = fl; bus_s.flush    = fl;
        bus_f.op       = o;  bus_s.op       = o;
        bus_f.left_operand  = a; bus_s.left_operand  = a;
        bus_f.right_operand = b; bus_s.right_operand = b;
        bus_f.rd_in    = rd; bus_s.rd_in    = rd;
    endtask

    // Plain-arithmetic model of every op, special cases included.
    function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa;
        longint      sb;
        logic [63:0] t;
        bit          ovf;
        sa  = $signed(a);
        sb  = $signed(b);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (o)
            3'd0: begin t = sa * sb; return t[31:0]; end
            3'd1: begin t = sa * sb; return t[63:32]; end
            3'd2: begin t = sa * longint'({32'd0, b}); return t[63:32]; end
            3'd3: begin t = {32'd0, a} * {32'd0, b}; return t[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                t = sa / sb; return t[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                t = sa % sb; return t[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] o, input logic [31:0] a,
                                      input logic [31:0] b);
        if (!o[2]) return 1'b0;
        if (b == 0) return 1'b1;
        return ((o == 3'd4) || (o == 3'd6)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    endfunction

    // Issue one request to both units and check result, rd, latency and stall.
    task automatic do_op(input string name, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input logic [31:0] want, input bit sp);
        int lat_f, lat_s, stall_f, stall_s, pulses_f, pulses_s;
        logic [31:0] res_f, res_s;
        logic [4:0]  rdo_f, rdo_s;
        lat_f = 0; lat_s = 0; stall_f = 0; stall_s = 0; pulses_f = 0; pulses_s = 0;
        res_f = '0; res_s = '0; rdo_f = '0; rdo_s = '0;
        @(posedge clk); #1;
        drive(1'b1, 1'b0, o, a, b, rd);
        @(negedge clk);
        if (bus_f.stall) stall_f++;
        if (bus_s.stall) stall_s++;
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 3'($urandom_range(0, 7)), $urandom, $urandom, 5'($urandom));
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus_f.stall) stall_f++;
            if (bus_s.stall) stall_s++;
            if (bus_f.out_valid) begin
                pulses_f++;
                if (lat_f == 0) begin lat_f = k; res_f = bus_f.result; rdo_f = bus_f.rd_out; end
            end
            if (bus_s.out_valid) begin
                pulses_s++;
                if (lat_s == 0) begin lat_s = k; res_s = bus_s.result; rdo_s = bus_s.rd_out; end
            end
        end
        check({name, " fast result"}, 64'(res_f), 64'(want));
        check({name, " slow result"}, 64'(res_s), 64'(want));
        check({name, " fast rd_out"}, 64'(rdo_f), 64'(rd));
        check({name, " slow rd_out"}, 64'(rdo_s), 64'(rd));
        check({name, " fast latency"}, 64'(lat_f), sp ? 64'd1 : 64'd33);
        check({name, " slow latency"}, 64'(lat_s), 64'd33);
        check({name, " fast stall cycles"}, 64'(stall_f), sp ? 64'd1 : 64'd33);
        check({name, " slow stall cycles"}, 64'(stall_s), 64'd33);
        check({name, " fast pulses"}, 64'(pulses_f), 64'd1);
        check({name, " slow pulses"}, 64'(pulses_s), 64'd1);
        last_res = want;
    endtask

    task automatic check_idle_outputs(input string name, input logic [31:0] res,
                                      input logic [4:0] rdv);
        check({name, " fast out_valid"}, 64'(bus_f.out_valid), 64'd0);
        check({name, " slow out_valid"}, 64'(bus_s.out_valid), 64'd0);
        check({name, " fast stall"}, 64'(bus_f.stall), 64'd0);
        check({name, " slow stall"}, 64'(bus_s.stall), 64'd0);
        check({name, " fast in_ready"}, 64'(bus_f.in_ready), 64'd1);
        check({name, " slow in_ready"}, 64'(bus_s.in_ready), 64'd1);
        check({name, " fast result"}, 64'(bus_f.result), 64'(res));
        check({name, " slow result"}, 64'(bus_s.result), 64'(res));
        if (rdv != 5'h1F) begin
            check({name, " fast rd_out"}, 64'(bus_f.rd_out), 64'(rdv));
            check({name, " slow rd_out"}, 64'(bus_s.rd_out), 64'(rdv));
        end
    endtask

    task automatic expect_silence(input string name);
        int pulses;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus_f.out_valid) pulses++;
            if (bus_s.out_valid) pulses++;
        end
        check({name, " no out_valid"}, 64'(pulses), 64'd0);
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra, rb;

        vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 1'b0};
        vecs[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 5'd6,  32'h4000_0000, 1'b0};
        vecs[2]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFF, 1'b0};
        vecs[3]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFE, 1'b0};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,         5'd9,  32'hFFFF_FFFD, 1'b0};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         5'd10, 32'hFFFF_FFFF, 1'b0};
        vecs[6]  = '{3'd5, 32'd100,       32'd7,         5'd11, 32'd14,        1'b0};
        vecs[7]  = '{3'd7, 32'd100,       32'd7,         5'd12, 32'd2,         1'b0};
        vecs[8]  = '{3'd4, 32'd5,         32'd0,         5'd13, 32'hFFFF_FFFF, 1'b1};
        vecs[9]  = '{3'd7, 32'd5,         32'd0,         5'd14, 32'd5,         1'b1};
        vecs[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1'b1};
        vecs[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0,         1'b1};
        vecs[12] = '{3'd4, 32'hFFFF_FFFB, 32'd0,         5'd17, 32'hFFFF_FFFF, 1'b1};
        vecs[13] = '{3'd6, 32'hFFFF_FFFB, 32'd0,         5'd18, 32'hFFFF_FFFB, 1'b1};
        vecs[14] = '{3'd5, 32'd5,         32'd0,         5'd19, 32'hFFFF_FFFF, 1'b1};
        vecs[15] = '{3'd0, 32'h1234_5678, 32'd0,         5'd20, 32'd0,         1'b0};

        rst = 1'b1;
        drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset", 32'd0, 5'd0);
        last_res = 32'd0;

        for (int i = 0; i < 16; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd,
                  vecs[i].want, vecs[i].sp);
        end

        for (int i = 0; i < 30; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 15));
                default: ;
            endcase
            do_op($sformatf("rand%0d op%0d", i, ro), ro, ra, rb, 5'($urandom),
                  ref_model(ro, ra, rb), is_special(ro, ra, rb));
        end

        // Flush during the tenth CALC cycle of a divide.
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 3'd5, 32'd100, 32'd7, 5'd21);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
        repeat (9) @(posedge clk);
        #1 drive(1'b0, 1'b1, 3'd0, 32'd0, 32'd0, 5'd0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
        @(negedge clk);
        check_idle_outputs("flush calc", last_res, 5'h1F);
        expect_silence("flush calc");

        // Flush in the same cycle as a request drops it.
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 3'd0, 32'd3, 32'd4, 5'd22);
        @(negedge clk);
        check("flush+valid fast stall", 64'(bus_f.stall), 64'd0);
        check("flush+valid slow stall", 64'(bus_s.stall), 64'd0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
        @(negedge clk);
        check_idle_outputs("flush+valid", last_res, 5'h1F);
        expect_silence("flush+valid");

        // Reset during the fifth cycle of a divide.
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd23);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("mid reset", 32'd0, 5'd0);
        expect_silence("mid reset");
        last_res = 32'd0;

        do_op("mul after reset", 3'd0, 32'd3, 32'd4, 5'd24, 32'd12, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/execute_muldiv_unit.md
Name: execute_muldiv_unit

Overview:
- Parametrised multi-cycle execute-stage unit for the RISC-V M extension: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Sits beside the single-cycle ALU in the execute stage. Receives already-forwarded operands.
- Holds the pipeline through `stall` while iterating. Returns a registered result with its destination register.
- Supports flush on branch redirect.

Parameters:
- XLEN, 32, operand and result width in bits; any even value ≥ 8.
- FAST_SPECIAL, 1, when 1, divide-by-zero and signed-overflow divides complete with 1-cycle latency.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  request operation this cycle
- in_ready  out  1  unit can accept; high only in IDLE
- op  in  3  funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- left_operand  in  XLEN  rs1 value (post-forwarding)
- right_operand  in  XLEN  rs2 value (post-forwarding)
- rd_in  in  5  destination register
- flush  in  1  kill in-flight or accepted operation
- stall  out  1  high while an accepted op has not yet produced out_valid
- out_valid  out  1  one-cycle pulse; result and rd_out valid
- result  out  XLEN  operation result, held until next out_valid
- rd_out  out  5  destination register of result

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst` is synchronous and active-high. Reset has priority over all inputs.
- Reset values: state IDLE, out_valid 0, stall 0, result 0, rd_out 0, counter 0. in_ready is 1 after reset.
- States:
  - IDLE → CALC on in_valid & !flush.
  - IDLE → DONE on in_valid & !flush when FAST_SPECIAL=1 and the op is a special case.
  - CALC → DONE when the counter reaches XLEN-1 on a clock edge.
  - DONE → IDLE always.
  - Any state → IDLE on flush.
- Accept: in IDLE, in_valid & !flush latches op, rd_in, and both operands. Operands are stored as magnitudes plus sign flags, with sign per op:
  - MULH, DIV, REM: both operands signed.
  - MULHSU: left operand signed, right unsigned.
  - All others: unsigned.
- stall: combinational. Equals `(state==IDLE & in_valid & !flush) | state==CALC`, so the op's own cycle is stalled.
- Multiply: radix-2 shift-add over XLEN cycles into a 2·XLEN accumulator. At DONE the sign is applied by two's-complement negation of the full 2·XLEN product when the sign flags differ. MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
- Divide: restoring division over XLEN cycles, one quotient bit per cycle.
  - Quotient sign is the XOR of the signs; remainder sign follows the dividend.
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
- Latency: out_valid is asserted exactly XLEN+1 cycles after the accept edge (33 for XLEN=32). For special cases with FAST_SPECIAL=1 it is asserted the cycle after accept.
- Special cases (results independent of FAST_SPECIAL; only latency differs):
  - Divisor 0: DIV/DIVU → all ones; REM/REMU → dividend.
  - DIV with dividend = most-negative and divisor = -1 → most-negative.
  - REM with the same operands → 0.
- out_valid: high only in DONE, one cycle. result and rd_out are registered when entering DONE and held afterwards. in_ready stays low in CALC and DONE; no back-to-back accept.
- Flush:
  - Flush during CALC or DONE: next state IDLE. out_valid is suppressed if not already high. result and rd_out keep their old values.
  - Flush in the same cycle as in_valid: the request is dropped.
  - Flush has priority over counter completion.
- Reset mid-CALC: next cycle IDLE with all reset values; no out_valid.
- in_valid while not in IDLE: ignored; operands are not re-sampled.

Test Plan:
- MUL, XLEN=32, 7 × 0xFFFFFFFD, in_valid one cycle → stall high 33 cycles. out_valid on cycle 33 with result 0xFFFFFFEB and rd_out = rd_in.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF. MULHU same operands → 0xFFFFFFFE.
- DIV -7 / 2 → 0xFFFFFFFD; REM -7 % 2 → 0xFFFFFFFF; DIVU 100 / 7 → 14; REMU → 2. Each with latency 33.
- FAST_SPECIAL=1:
  - DIV 5/0 → 0xFFFFFFFF with out_valid next cycle; REMU 5%0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM same operands → 0.
  - Repeat all with FAST_SPECIAL=0 → same values, latency 33.
- Flush at cycle 10 of CALC → no out_valid, stall low and in_ready high the next cycle, result unchanged. Flush together with in_valid → nothing accepted.
- rst asserted at cycle 5 of a DIV → next cycle all outputs at reset values. A new MUL 3×4 accepted after reset → 12.
